// File: rtl/rv_regfile_mp.sv
// Multi-ported integer register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
module rv_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_addr_i,
  output logic [NREG-1:0]     busy_o
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  // Later ports are visited last, so the highest-index port wins a collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] != '0)) begin
          regs[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  // A same-edge issue overrides the clear from a write: the new producer owns the register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k]) begin
          busy[wr_addr_i[k*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_en_i && (iss_addr_i != '0)) begin
        busy[iss_addr_i] <= 1'b1;
      end
    end
  end

  // Forwarding is suppressed during reset so held-off writes never leak to the read ports.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data_o[p*XLEN +: XLEN] = regs[rd_addr_i[p*AW +: AW]];
      rd_busy_o[p]              = busy[rd_addr_i[p*AW +: AW]];
      if ((BYPASS != 0) && !rst_i && (rd_addr_i[p*AW +: AW] != '0)) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
            rd_data_o[p*XLEN +: XLEN] = wr_data_i[k*XLEN +: XLEN];
            rd_busy_o[p]              = 1'b0;
          end
        end
      end
    end
  end

  assign busy_o = busy;

endmodule

// File: doc/rv_regfile_mp.md
RV_REGFILE_MP -- requirements
Module: rv_regfile_mp

Interface
REQ-001 The block SHALL have the parameter XLEN, default 32, giving the register data width.
REQ-002 The block SHALL have the parameter NREG, default 32, giving the register count (power of two, at least 2); AW = log2(NREG).
REQ-003 The block SHALL have the parameter NRD, default 3, giving the number of read ports.
REQ-004 The block SHALL have the parameter NWR, default 2, giving the number of write ports.
REQ-005 The block SHALL have the parameter BYPASS, default 1; 1 = write-to-read forwarding, 0 = read returns the stored value.
REQ-006 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have the port rst_i, input, 1 bit: the reset, asynchronous and active-high.
REQ-008 The block SHALL have the port rd_addr_i, input, NRD*AW bits: read addresses; port k occupies bits [k*AW +: AW].
REQ-009 The block SHALL have the port rd_data_o, output, NRD*XLEN bits: read data, per-port slices.
REQ-010 The block SHALL have the port rd_busy_o, output, NRD bits: a pending write exists for that port's read address.
REQ-011 The block SHALL have the port wr_en_i, input, NWR bits: per-port write enables.
REQ-012 The block SHALL have the port wr_addr_i, input, NWR*AW bits: write addresses.
REQ-013 The block SHALL have the port wr_data_i, input, NWR*XLEN bits: write data.
REQ-014 The block SHALL have the port iss_en_i, input, 1 bit: issue strobe that marks iss_addr_i as pending.
REQ-015 The block SHALL have the port iss_addr_i, input, AW bits: the destination register being issued.
REQ-016 The block SHALL have the port busy_o, output, NREG bits: the full scoreboard; bit r = register r pending.

Function
REQ-017 Register 0 SHALL always read 0, ignore all writes and issues, and never be busy.
REQ-018 On a clock edge, each write port k with wr_en_i[k]=1 and a nonzero address SHALL store its write data.
REQ-019 When several enabled write ports target the same address in one cycle, the highest-index port SHALL win; the other ports' data is discarded.
REQ-020 Reads SHALL be combinational with zero-cycle latency; all NRD ports are independent and may share an address.
REQ-021 With BYPASS=1, a read of a nonzero address matching any enabled write port in the same cycle SHALL return that write port's data (highest-index match per REQ-019); otherwise it returns the stored value.
REQ-022 With BYPASS=0, a read SHALL return the value stored before the current edge, regardless of same-cycle writes.
REQ-023 busy[r] SHALL be set on the edge where iss_en_i=1, iss_addr_i=r and r is not 0.
REQ-024 busy[r] SHALL be cleared on the edge where any enabled write port targets r.
REQ-025 When an issue and a write target the same register on the same edge, busy[r] SHALL end set (the new producer wins); the write data is still stored.
REQ-026 rd_busy_o[k] SHALL equal busy[rd_addr] for each read port; with BYPASS=1 it SHALL be forced to 0 when the read address matches a same-cycle write.
REQ-027 Writes to registers that are not busy SHALL be accepted and leave busy unchanged.
REQ-028 Address decoding SHALL be full-width with no wrap; every address 0..NREG-1 is legal.

Reset
REQ-029 While rst_i is high, all registers SHALL be held at 0 and busy_o SHALL be all 0, asynchronously, with no clock required.
REQ-030 Writes and issues presented while rst_i is high SHALL have no effect.
REQ-031 A reset asserted mid-operation SHALL discard all pending scoreboard state.
REQ-032 The first state update after reset SHALL occur on the first rising clock edge after rst_i falls.

Verification
REQ-033 Reset, then read all 32 addresses on 3 ports -> every rd_data_o=0, busy_o=0.
REQ-034 Write port0 x5=0xDEADBEEF and port1 x5=0x12345678 on one edge -> next cycle x5 reads 0x12345678; with BYPASS=1, all read ports on x5 show 0x12345678 during the write cycle.
REQ-035 Write x0=0xFFFFFFFF and issue x0 -> x0 reads 0, busy_o[0]=0.
REQ-036 Issue x7; next cycle rd_busy_o=1 for a read of x7; write x7=0xA5 -> busy clears after the edge; write x7 while issuing x7 on the same edge -> busy_o[7]=1 and x7=0xA5.
REQ-037 BYPASS=0, write x3=0x55 while reading x3 (old value 0) -> read shows 0 that cycle and 0x55 next cycle.
REQ-038 Load x1..x31 with distinct data, assert rst_i between clock edges -> all outputs 0 immediately; deassert -> contents stay 0.
